gx_reconfig_arbiter: RTL and testbench

GX_RECONFIG_ARBITER -- requirements
Module: gx_reconfig_arbiter

---
 rtl/gx_reconfig_arbiter_if.sv | 41 ++++
 rtl/gx_reconfig_arbiter.sv | 176 +++++++++++++++++
 tb/tb_gx_reconfig_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gx_reconfig_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module   : gx_reconfig_arbiter_if
// Brief    : Requester-side and reconfig-master-side bus bundle for the arbiter.
// Revision : 1.0 - initial release
// =============================================================================
interface gx_reconfig_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int LADDR_W = 10
);
    logic [NUM_REQ-1:0]         req_write;
    logic [NUM_REQ-1:0]         req_read;
    logic [NUM_REQ*LADDR_W-1:0] req_address;
    logic [NUM_REQ*32-1:0]      req_writedata;
    logic [NUM_REQ-1:0]         req_waitrequest;
    logic [31:0]                req_readdata;

    logic                       reconfig_write;
    logic                       reconfig_read;
    logic [LADDR_W+1:0]         reconfig_address;
    logic [31:0]                reconfig_writedata;
    logic [31:0]                reconfig_readdata;
    logic                       reconfig_waitrequest;

    // Arbiter view: slave towards the requesters, drives the reconfig port.
    modport slave (
        input  req_write, req_read, req_address, req_writedata,
        input  reconfig_readdata, reconfig_waitrequest,
        output req_waitrequest, req_readdata,
        output reconfig_write, reconfig_read, reconfig_address, reconfig_writedata
    );

    // Environment view: requesters plus the transceiver reconfig slave.
    modport master (
        output req_write, req_read, req_address, req_writedata,
        output reconfig_readdata, reconfig_waitrequest,
        input  req_waitrequest, req_readdata,
        input  reconfig_write, reconfig_read, reconfig_address, reconfig_writedata
    );
endinterface
`default_nettype wire

// File: rtl/gx_reconfig_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : gx_reconfig_arbiter
// Brief    : Round-robin arbiter sharing one transceiver reconfig port among
//            NUM_REQ channels, with a per-transfer waitrequest timeout.
// Revision : 1.0 - initial release
// =============================================================================
module gx_reconfig_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int LADDR_W = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic                  reconfig_clk,
    input  logic                  reconfig_reset_n,
    gx_reconfig_arbiter_if.slave  bus,
    output logic                  timeout_err
);

    localparam int               c_cnt_w        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(TIMEOUT - 1);
    localparam logic [31:0]      c_timeout_data = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic [1:0]           last_grant_q, last_grant_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 rc_write_q, rc_write_d;
    logic                 rc_read_q, rc_read_d;
    logic [LADDR_W+1:0]   rc_address_q, rc_address_d;
    logic [31:0]          rc_wdata_q, rc_wdata_d;
    logic [NUM_REQ-1:0]   req_wait_q, req_wait_d;
    logic [31:0]          req_rdata_q, req_rdata_d;
    logic                 timeout_err_q, timeout_err_d;

    logic [3:0]           wr_vec;
    logic [3:0]           pend_vec;
    logic [LADDR_W-1:0]   addr_arr  [4];
    logic [31:0]          wdata_arr [4];
    logic [NUM_REQ-1:0]   ack_n;
    logic [2:0]           cand_sum;
    logic [1:0]           cand;
    logic [1:0]           winner;
    logic                 found;

    // Requester fields padded to four slots so a 2-bit channel index selects cleanly.
    for (genvar i = 0; i < 4; i++) begin : g_unpack
        if (i < NUM_REQ) begin : g_live
            assign wr_vec[i]    = bus.req_write[i];
            assign pend_vec[i]  = bus.req_write[i] | bus.req_read[i];
            assign addr_arr[i]  = bus.req_address[i*LADDR_W +: LADDR_W];
            assign wdata_arr[i] = bus.req_writedata[i*32 +: 32];
        end else begin : g_pad
            assign wr_vec[i]    = 1'b0;
            assign pend_vec[i]  = 1'b0;
            assign addr_arr[i]  = '0;
            assign wdata_arr[i] = '0;
        end
    end

    // Search begins one past the previous winner; the sum never exceeds 2*NUM_REQ-1.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum = {1'b0, last_grant_q} + 3'(k);
            cand     = (cand_sum >= 3'(NUM_REQ)) ? 2'(cand_sum - 3'(NUM_REQ)) : cand_sum[1:0];
            if (!found && pend_vec[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign ack_n = ~(NUM_REQ'(1) << grant_q);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        rc_write_d    = rc_write_q;
        rc_read_d     = rc_read_q;
        rc_address_d  = rc_address_q;
        rc_wdata_d    = rc_wdata_q;
        req_wait_d    = '1;
        req_rdata_d   = req_rdata_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = GRANT;
                    grant_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = '0;
                    rc_write_d   = wr_vec[winner];
                    rc_read_d    = ~wr_vec[winner];
                    rc_address_d = {winner, addr_arr[winner]};
                    rc_wdata_d   = wdata_arr[winner];
                end
            end
            GRANT: begin
                if (!bus.reconfig_waitrequest) begin
                    if (rc_read_q) begin
                        req_rdata_d = bus.reconfig_readdata;
                    end
                    rc_write_d = 1'b0;
                    rc_read_d  = 1'b0;
                    req_wait_d = ack_n;
                    state_d    = DONE;
                end else if (cnt_q == c_cnt_last) begin
                    rc_write_d    = 1'b0;
                    rc_read_d     = 1'b0;
                    req_rdata_d   = c_timeout_data;
                    timeout_err_d = 1'b1;
                    req_wait_d    = ack_n;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= 2'(NUM_REQ - 1);
            cnt_q         <= '0;
            rc_write_q    <= 1'b0;
            rc_read_q     <= 1'b0;
            rc_address_q  <= '0;
            rc_wdata_q    <= '0;
            req_wait_q    <= '1;
            req_rdata_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            rc_write_q    <= rc_write_d;
            rc_read_q     <= rc_read_d;
            rc_address_q  <= rc_address_d;
            rc_wdata_q    <= rc_wdata_d;
            req_wait_q    <= req_wait_d;
            req_rdata_q   <= req_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.reconfig_write     = rc_write_q;
    assign bus.reconfig_read      = rc_read_q;
    assign bus.reconfig_address   = rc_address_q;
    assign bus.reconfig_writedata = rc_wdata_q;
    assign bus.req_waitrequest    = req_wait_q;
    assign bus.req_readdata       = req_rdata_q;
    assign timeout_err            = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gx_reconfig_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_gx_reconfig_arbiter
// Brief    : Directed bench with a transaction-level reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_gx_reconfig_arbiter;

    localparam int NUM_REQ = 3;
    localparam int LADDR_W = 10;
    localparam int TIMEOUT = 16;
    localparam int M_WAIT  = 0;
    localparam int M_XFER  = 1;
    localparam int M_ACK   = 2;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        timeout_err;
    logic [31:0] slave_rdata = 32'h0;
    int          slave_delay = 0;
    int          hold_cnt    = 0;
    bit          chk_en      = 1'b0;
    int          n_checks    = 0;
    int          n_fail      = 0;
    int          grant_log[$];

    gx_reconfig_arbiter_if #(.NUM_REQ(NUM_REQ), .LADDR_W(LADDR_W)) bif ();

    gx_reconfig_arbiter #(
        .NUM_REQ(NUM_REQ),
        .LADDR_W(LADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .reconfig_clk     (clk),
        .reconfig_reset_n (rst_n),
        .bus              (bif),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    assign bif.reconfig_readdata = slave_rdata;

    // Reconfig slave: stalls slave_delay cycles of each transfer, then accepts.
    always @(negedge clk) begin
        if (bif.reconfig_write || bif.reconfig_read) begin
            if (hold_cnt < slave_delay) begin
                bif.reconfig_waitrequest <= 1'b1;
                hold_cnt                 <= hold_cnt + 1;
            end else begin
                bif.reconfig_waitrequest <= 1'b0;
            end
        end else begin
            bif.reconfig_waitrequest <= 1'b1;
            hold_cnt                 <= 0;
        end
    end

    // ---------------- reference model ----------------
    int          m_phase    = M_WAIT;
    int          m_owner    = 0;
    int          m_last     = NUM_REQ - 1;
    int          m_gcnt     = 0;
    bit          m_is_write = 1'b0;
    logic [9:0]  m_addr     = '0;
    logic [31:0] m_wdata    = '0;
    logic [31:0] m_rdata    = '0;
    bit          m_err      = 1'b0;
    int          m_pick;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] pend, input int last);
        for (int step = 1; step <= NUM_REQ; step++) begin
            if (pend[(last + step) % NUM_REQ] === 1'b1) return (last + step) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] exp_wait(input int ph, input int own);
        logic [NUM_REQ-1:0] v = '1;
        if (ph == M_ACK) v[own] = 1'b0;
        return v;
    endfunction

    assign m_pick = rr_pick(bif.req_write | bif.req_read, m_last);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= M_WAIT;
            m_last  <= NUM_REQ - 1;
            m_rdata <= '0;
            m_err   <= 1'b0;
            m_gcnt  <= 0;
        end else begin
            case (m_phase)
                M_WAIT: if (m_pick >= 0) begin
                    m_phase    <= M_XFER;
                    m_owner    <= m_pick;
                    m_last     <= m_pick;
                    m_is_write <= bif.req_write[m_pick];
                    m_addr     <= bif.req_address[m_pick*LADDR_W +: LADDR_W];
                    m_wdata    <= bif.req_writedata[m_pick*32 +: 32];
                    m_gcnt     <= 1;
                end
                M_XFER: if (!bif.reconfig_waitrequest) begin
                    if (!m_is_write) m_rdata <= bif.reconfig_readdata;
                    m_phase <= M_ACK;
                end else if (m_gcnt == TIMEOUT) begin
                    m_rdata <= 32'hDEADBEEF;
                    m_err   <= 1'b1;
                    m_phase <= M_ACK;
                end else begin
                    m_gcnt <= m_gcnt + 1;
                end
                default: m_phase <= M_WAIT;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_write", bif.reconfig_write, (m_phase == M_XFER) && m_is_write);
            chk("cyc_read", bif.reconfig_read, (m_phase == M_XFER) && !m_is_write);
            if (m_phase == M_XFER) chk("cyc_address", bif.reconfig_address, {2'(m_owner), m_addr});
            if (m_phase == M_XFER && m_is_write) chk("cyc_wdata", bif.reconfig_writedata, m_wdata);
            chk("cyc_waitreq", bif.req_waitrequest, exp_wait(m_phase, m_owner));
            chk("cyc_readdata", bif.req_readdata, m_rdata);
            chk("cyc_timeout_err", timeout_err, m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input int i, input bit wr, input bit rd,
                           input logic [LADDR_W-1:0] a, input logic [31:0] d);
        bif.req_write[i]                       = wr;
        bif.req_read[i]                        = rd;
        bif.req_address[i*LADDR_W +: LADDR_W]  = a;
        bif.req_writedata[i*32 +: 32]          = d;
    endtask

    task automatic single(input int i, input bit wr, input bit rd, input logic [LADDR_W-1:0] a,
                          input logic [31:0] d, input int delay, input bit drop_early,
                          output int lat, output int gcycles, output logic [11:0] gaddr,
                          output logic [1:0] gop, output logic [31:0] rdat, output bit done_seen);
        slave_delay = delay;
        lat = 0; gcycles = 0; gaddr = '0; gop = '0; rdat = '0; done_seen = 1'b0;
        @(negedge clk);
        set_req(i, wr, rd, a, d);
        for (int c = 0; c < 100 && !done_seen; c++) begin
            @(negedge clk);
            if (bif.reconfig_write || bif.reconfig_read) begin
                if (gcycles == 0) begin
                    gaddr = bif.reconfig_address;
                    gop   = {bif.reconfig_write, bif.reconfig_read};
                    if (drop_early) set_req(i, 1'b0, 1'b0, a, d);
                end
                gcycles++;
            end
            if (!bif.req_waitrequest[i]) begin
                done_seen = 1'b1;
                lat       = c + 2;
                rdat      = bif.req_readdata;
                set_req(i, 1'b0, 1'b0, a, d);
            end
        end
        if (!done_seen) set_req(i, 1'b0, 1'b0, a, d);
    endtask

    task automatic run_all(input int n);
        int left   [NUM_REQ];
        int issued [NUM_REQ];
        int total;
        slave_delay = 0;
        grant_log.delete();
        total = NUM_REQ * n;
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            left[i] = n; issued[i] = 0;
            set_req(i, 1'b1, 1'b0, LADDR_W'(16 * i + 1), 32'(i * 256));
        end
        for (int c = 0; c < 200 && total > 0; c++) begin
            @(negedge clk);
            if (bif.reconfig_write || bif.reconfig_read) grant_log.push_back(int'(bif.reconfig_address[11:10]));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (left[i] > 0 && !bif.req_waitrequest[i]) begin
                    left[i]--; issued[i]++; total--;
                    if (left[i] == 0) set_req(i, 1'b0, 1'b0, '0, '0);
                    else set_req(i, 1'b1, 1'b0, LADDR_W'(16 * i + 1 + issued[i]), 32'(i * 256 + issued[i]));
                end
            end
        end
        chk("rr_all_done", total, 0);
    endtask

    initial begin
        int          lat, gc, first;
        logic [11:0] ga;
        logic [1:0]  op;
        logic [31:0] rd;
        bit          ok, ack_seen, act1, act2;

        bif.req_write = '0; bif.req_read = '0; bif.req_address = '0; bif.req_writedata = '0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_write", bif.reconfig_write, 0);
        chk("rst_read", bif.reconfig_read, 0);
        chk("rst_address", bif.reconfig_address, 0);
        chk("rst_wdata", bif.reconfig_writedata, 0);
        chk("rst_waitreq", bif.req_waitrequest, 3'b111);
        chk("rst_readdata", bif.req_readdata, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // req0 write, immediate accept
        single(0, 1, 0, 10'h010, 32'h12345678, 0, 0, lat, gc, ga, op, rd, ok);
        chk("w0_done", ok, 1); chk("w0_ack_cycle", lat, 3); chk("w0_strobe_cycles", gc, 1);
        chk("w0_address", ga, 12'h010); chk("w0_op", op, 2'b10);

        // req1 read+write together: write wins
        single(1, 1, 1, 10'h055, 32'hA5A5A5A5, 0, 0, lat, gc, ga, op, rd, ok);
        chk("rw1_done", ok, 1); chk("rw1_op", op, 2'b10); chk("rw1_address", ga, 12'h455);

        // req2 read with 4 stall cycles
        slave_rdata = 32'hCAFEF00D;
        single(2, 0, 1, 10'h3FF, 32'h0, 4, 0, lat, gc, ga, op, rd, ok);
        chk("r2_done", ok, 1); chk("r2_address", ga, 12'hBFF); chk("r2_strobe_cycles", gc, 5);
        chk("r2_ack_cycle", lat, 7); chk("r2_readdata", rd, 32'hCAFEF00D); chk("r2_op", op, 2'b01);

        // all three write continuously
        run_all(2);
        chk("rr_count", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) chk($sformatf("rr_order%0d", k), grant_log[k], k % 3);

        // strobe dropped mid-transfer still completes
        single(0, 1, 0, 10'h1AB, 32'h0BADF00D, 2, 1, lat, gc, ga, op, rd, ok);
        chk("drop_done", ok, 1); chk("drop_strobe_cycles", gc, 3);

        // stuck slave -> timeout
        single(0, 0, 1, 10'h077, 32'h0, 1000, 0, lat, gc, ga, op, rd, ok);
        chk("to_done", ok, 1); chk("to_strobe_cycles", gc, TIMEOUT);
        chk("to_readdata", rd, 32'hDEADBEEF); chk("to_err", timeout_err, 1);
        single(1, 1, 0, 10'h011, 32'h1, 1, 0, lat, gc, ga, op, rd, ok);
        chk("to_w_done", ok, 1); chk("to_w_readdata_kept", rd, 32'hDEADBEEF); chk("to_err_sticky1", timeout_err, 1);
        slave_rdata = 32'h11223344;
        single(2, 0, 1, 10'h012, 32'h0, 0, 0, lat, gc, ga, op, rd, ok);
        chk("to_r_done", ok, 1); chk("to_r_readdata", rd, 32'h11223344); chk("to_err_sticky2", timeout_err, 1);

        // reset in the middle of a transfer
        slave_delay = 1000;
        @(negedge clk);
        set_req(1, 1'b0, 1'b1, 10'h022, 32'h0);
        repeat (3) @(negedge clk);
        chk("mid_grant_read", bif.reconfig_read, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_write", bif.reconfig_write, 0);
        chk("arst_read", bif.reconfig_read, 0);
        chk("arst_waitreq", bif.req_waitrequest, 3'b111);
        chk("arst_err", timeout_err, 0);
        set_req(2, 1'b1, 1'b0, 10'h033, 32'h55AA55AA);
        ack_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bif.req_waitrequest !== 3'b111) ack_seen = 1'b1;
        end
        chk("arst_no_done", ack_seen, 0);
        slave_delay = 0;
        rst_n = 1'b1;
        first = -1; act1 = 1'b1; act2 = 1'b1;
        for (int c = 0; c < 40 && (act1 || act2); c++) begin
            @(negedge clk);
            if (first < 0 && (bif.reconfig_write || bif.reconfig_read)) first = int'(bif.reconfig_address[11:10]);
            if (act1 && !bif.req_waitrequest[1]) begin act1 = 1'b0; set_req(1, 1'b0, 1'b0, '0, '0); end
            if (act2 && !bif.req_waitrequest[2]) begin act2 = 1'b0; set_req(2, 1'b0, 1'b0, '0, '0); end
        end
        chk("arst_first_grant", first, 1);
        chk("arst_both_done", {act1, act2}, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
